// File: rtl/ultra_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ultra_pkg -- shared types, widths and the double-dabble step.  Rev 1.0
// ----------------------------------------------------------------------------
package ultra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    CONVERT,
    UPDATE
  } state_e;

  localparam int CM_W  = 14;
  localparam int BCD_W = 16;
  localparam logic [CM_W-1:0] CM_MAX = 14'd9999;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  function automatic logic [BCD_W+CM_W-1:0] dabble_step(input logic [BCD_W+CM_W-1:0] sr);
    logic [BCD_W+CM_W-1:0] t;
    t = sr;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (t[CM_W + 4*i +: 4] >= 4'd5) begin
        t[CM_W + 4*i +: 4] = t[CM_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[BCD_W+CM_W-2:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ultra_bin2bcd.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ultra_bin2bcd -- sequential 14-bit binary to 4-digit BCD (double dabble).
// Rev 1.0
// ----------------------------------------------------------------------------
module ultra_bin2bcd
  import ultra_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CM_W-1:0]  bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  localparam int SR_W = BCD_W + CM_W;
  localparam logic [3:0] LAST_SHIFT = 4'(CM_W - 1);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [SR_W-1:0]  step;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d  = bcd_q;
    step   = dabble_step(sr_q);
    if (!busy_q) begin
      if (start) begin
        sr_d   = {{BCD_W{1'b0}}, bin};
        cnt_d  = 4'd0;
        busy_d = 1'b1;
      end
    end else begin
      sr_d = step;
      if (cnt_q == LAST_SHIFT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        bcd_d  = step[SR_W-1:CM_W];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q  <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/ultra_range.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ultra_range -- periodic sensor trigger, echo width in whole cm, held BCD
// digits for the display.  Rev 1.0
// ----------------------------------------------------------------------------
module ultra_range
  import ultra_pkg::*;
#(
  parameter int TICKS_PER_CM = 2900,
  parameter int TRIG_TICKS   = 500,
  parameter int PERIOD_TICKS = 3000000,
  parameter int ECHO_TIMEOUT = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo,
  output logic       trig,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       range_err,
  output logic       done
);

  localparam int PER_W  = $clog2(PERIOD_TICKS + 1);
  localparam int TRG_W  = $clog2(TRIG_TICKS + 1);
  localparam int TO_W   = $clog2(ECHO_TIMEOUT + 1);
  localparam int TICK_W = $clog2(TICKS_PER_CM);

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_TICKS - 1);
  localparam logic [TRG_W-1:0]  TRG_LAST  = TRG_W'(TRIG_TICKS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ECHO_TIMEOUT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_CM - 1);

  logic              echo_meta_q, echo_s_q;
  logic [PER_W-1:0]  per_q;
  state_e            state_q, state_d;
  logic [TRG_W-1:0]  trg_q, trg_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CM_W-1:0]   cm_q, cm_d;
  logic              armed_q, armed_d;
  logic              err_q, err_d;
  logic              trig_q;
  logic              done_q;
  logic              range_err_q;
  logic [BCD_W-1:0]  digits_q;

  logic              conv_start;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_busy;
  logic              conv_done;

  ultra_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (cm_q),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  always_comb begin
    state_d    = state_q;
    trg_d      = trg_q;
    to_d       = to_q;
    tick_d     = tick_q;
    cm_d       = cm_q;
    armed_d    = armed_q;
    err_d      = err_q;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (per_q == PER_LAST) begin
          state_d = TRIG;
          trg_d   = '0;
        end
      end
      TRIG: begin
        to_d    = '0;
        armed_d = 1'b0;
        err_d   = 1'b0;
        if (trg_q == TRG_LAST) begin
          state_d = WAIT_ECHO;
        end else begin
          trg_d = trg_q + 1'b1;
        end
      end
      WAIT_ECHO: begin
        if (to_q == TO_LAST) begin
          cm_d    = CM_MAX;
          err_d   = 1'b1;
          state_d = CONVERT;
        end else begin
          to_d = to_q + 1'b1;
          if (!echo_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // The edge cycle is itself the first high tick of the pulse.
            tick_d  = TICK_W'(1);
            cm_d    = '0;
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (to_q == TO_LAST) begin
          cm_d    = CM_MAX;
          err_d   = 1'b1;
          state_d = CONVERT;
        end else begin
          to_d = to_q + 1'b1;
          if (echo_s_q) begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              if (cm_q != CM_MAX) begin
                cm_d = cm_q + 1'b1;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end else begin
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        conv_start = !conv_busy && !conv_done;
        if (conv_done) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      per_q       <= '0;
      state_q     <= IDLE;
      trg_q       <= '0;
      to_q        <= '0;
      tick_q      <= '0;
      cm_q        <= '0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      digits_q    <= '0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      per_q       <= (per_q == PER_LAST) ? '0 : per_q + 1'b1;
      state_q     <= state_d;
      trg_q       <= trg_d;
      to_q        <= to_d;
      tick_q      <= tick_d;
      cm_q        <= cm_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
      trig_q      <= (state_d == TRIG);
      done_q      <= (state_q == UPDATE);
      // Digits and error flag move together so the display never tears.
      if (state_q == UPDATE) begin
        digits_q    <= conv_bcd;
        range_err_q <= err_q;
      end
    end
  end

  assign trig      = trig_q;
  assign done      = done_q;
  assign range_err = range_err_q;
  assign digit0    = digits_q[15:12];
  assign digit1    = digits_q[11:8];
  assign digit2    = digits_q[7:4];
  assign digit3    = digits_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_ultra_range.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ultra_range -- randomized echo widths against a cm/BCD reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ultra_range;

  localparam int TPC    = 4;
  localparam int TRIGW  = 3;
  localparam int PERIOD = 2000;
  localparam int TMO    = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic       echo;
  logic       trig;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       range_err;
  logic       done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_rise;

  ultra_range #(
    .TICKS_PER_CM (TPC),
    .TRIG_TICKS   (TRIGW),
    .PERIOD_TICKS (PERIOD),
    .ECHO_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .echo      (echo),
    .trig      (trig),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .range_err (range_err),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_cm(input int high_cycles);
    int c;
    c = high_cycles / TPC;
    if (c > 9999) c = 9999;
    return c;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next trig rise, check its offset from ref_cyc and its width.
  task automatic wait_trig(input int ref_cyc, input int exp_gap, input string tag, output int dones);
    int gap;
    int w;
    gap   = -1;
    dones = 0;
    for (int k = 1; k <= 2 * PERIOD + 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (trig === 1'b1) begin
        gap = cyc - ref_cyc;
        break;
      end
    end
    check({tag, "_gap"}, gap, exp_gap);
    last_rise = cyc;
    w = 0;
    for (int k = 0; k < 20; k++) begin
      if (trig !== 1'b1) break;
      w++;
      @(negedge clk);
    end
    check({tag, "_width"}, w, TRIGW);
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int cm, input bit err);
    check({tag, "_digits"}, {digit0, digit1, digit2, digit3}, to_bcd(cm));
    check({tag, "_err"}, range_err, err);
    @(negedge clk);
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  task automatic run_echo(input string tag, input int dly, input int h);
    int lat;
    repeat (dly) @(negedge clk);
    echo = 1'b1;
    repeat (h) @(negedge clk);
    echo = 1'b0;
    wait_done(60, lat);
    check({tag, "_lat"}, lat, 20);
    check_result(tag, exp_cm(h), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int lat;
    int rel;
    int h;
    int d;

    rst  = 1'b1;
    echo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 1'b0);
    check("rst_digits", {digit0, digit1, digit2, digit3}, 16'h0000);
    check("rst_err", range_err, 1'b0);
    check("rst_done", done, 1'b0);

    rst = 1'b0;
    rel = cyc;
    wait_trig(rel, PERIOD, "first_trig", dn);
    check("pre_update_digits", {digit0, digit1, digit2, digit3}, 16'h0000);
    run_echo("e492", 10, 492);

    wait_trig(last_rise, PERIOD, "trig2", dn);
    run_echo("e495", 7, 495);
    wait_trig(last_rise, PERIOD, "trig3", dn);
    run_echo("e3", 20, 3);

    wait_trig(last_rise, PERIOD, "trig4", dn);
    wait_done(TMO + 100, lat);
    check("noecho_done_seen", lat > 0, 1'b1);
    check_result("noecho", 9999, 1'b1);

    wait_trig(last_rise, PERIOD, "trig5", dn);
    run_echo("e40", 4, 40);

    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(1, 1300);
      d = $urandom_range(1, 40);
      wait_trig(last_rise, PERIOD, $sformatf("rtrig%0d", i), dn);
      run_echo($sformatf("rnd%0d_h%0d", i, h), d, h);
    end

    // Echo already high when the trigger ends: only the later pulse counts.
    echo = 1'b1;
    wait_trig(last_rise, PERIOD, "trig_hi", dn);
    repeat (10) @(negedge clk);
    echo = 1'b0;
    run_echo("stale_hi", 5, 200);

    wait_trig(last_rise, PERIOD, "trig_stuck", dn);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    wait_done(TMO + 100, lat);
    check("stuck_done_seen", lat > 0, 1'b1);
    check_result("stuck", 9999, 1'b1);
    echo = 1'b0;

    wait_trig(last_rise, PERIOD, "trig_rst", dn);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_trig", trig, 1'b0);
    check("midrst_digits", {digit0, digit1, digit2, digit3}, 16'h0000);
    check("midrst_err", range_err, 1'b0);
    check("midrst_done", done, 1'b0);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    wait_trig(rel, PERIOD, "post_rst_trig", dn);
    check("post_rst_no_done", dn, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
